// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera register configuration sequencer
// and the config ROM that feeds it.
package cam_cfg_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [WORD_W-1:0] CFG_END   = 16'hFFFF;
  localparam logic [WORD_W-1:0] CFG_DELAY = 16'hFFF0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT_ROM,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_BUS,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } cfg_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] regaddr;
    logic [BYTE_W-1:0] value;
  } sccb_wr_t;

  // Reload value for a delay entry; the timer counts from here down to zero.
  function automatic int unsigned delay_cycles(input int unsigned clk_hz,
                                               input int unsigned delay_us);
    int unsigned cyc;
    cyc = (clk_hz / 32'd1_000_000) * delay_us;
    return (cyc > 0) ? cyc - 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter; emits a one-cycle expired pulse after reaching zero.
module cfg_delay_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] cnt_q;
  logic         run_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q     <= '0;
      run_q     <= 1'b0;
      o_expired <= 1'b0;
    end else begin
      o_expired <= 1'b0;
      if (i_clr) begin
        cnt_q <= '0;
        run_q <= 1'b0;
      end else if (i_load) begin
        cnt_q <= i_load_val;
        run_q <= 1'b1;
      end else if (run_q) begin
        if (cnt_q == '0) begin
          run_q     <= 1'b0;
          o_expired <= 1'b1;
        end else begin
          cnt_q <= cnt_q - W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cam_cfg_seq.sv
// Walks a config ROM and turns each entry into an SCCB register write,
// a fixed delay, or end-of-sequence; NACKed writes are retried.
module cam_cfg_seq
  import cam_cfg_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned DELAY_US  = 1000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_restart,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [WORD_W-1:0] i_rom_data,
  output logic              o_sccb_valid,
  output logic [BYTE_W-1:0] o_sccb_reg,
  output logic [BYTE_W-1:0] o_sccb_dat,
  input  logic              i_sccb_ready,
  input  logic              i_sccb_done,
  input  logic              i_sccb_nack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned DELAY_CYC = delay_cycles(CLK_HZ, DELAY_US);
  localparam int unsigned CNT_W     = (DELAY_CYC > 0) ? $clog2(DELAY_CYC + 1) : 1;
  localparam int unsigned RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  cfg_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  sccb_wr_t            req_q, req_d;
  logic                valid_q, valid_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                tmr_load;
  logic                tmr_expired;
  logic                at_last;

  cfg_delay_timer #(.W(CNT_W)) u_delay (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_clr      (i_restart),
    .i_load     (tmr_load),
    .i_load_val (CNT_W'(DELAY_CYC)),
    .o_expired  (tmr_expired)
  );

  assign at_last = (addr_q == '1);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_FETCH;
      addr_q  <= '0;
      word_q  <= '0;
      req_q   <= '0;
      valid_q <= 1'b0;
      retry_q <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      retry_q <= retry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-register values; restart overrides everything below.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    word_d   = word_q;
    req_d    = req_q;
    valid_d  = valid_q;
    retry_d  = retry_q;
    tmr_load = 1'b0;

    case (state_q)
      ST_FETCH:    state_d = ST_WAIT_ROM;
      ST_WAIT_ROM: begin
        word_d  = i_rom_data;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (word_q == CFG_END) begin
          state_d = ST_DONE;
        end else if (word_q == CFG_DELAY) begin
          tmr_load = 1'b1;
          state_d  = ST_DELAY;
        end else begin
          req_d   = sccb_wr_t'(word_q);
          valid_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_sccb_ready) begin
          valid_d = 1'b0;
          state_d = ST_WAIT_BUS;
        end
      end
      ST_WAIT_BUS: begin
        if (i_sccb_done) begin
          if (!i_sccb_nack) begin
            retry_d = '0;
            if (at_last) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_FETCH;
            end
          end else if (retry_q == RETRY_W'(MAX_RETRY)) begin
            state_d = ST_ERROR;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            valid_d = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DELAY: begin
        if (tmr_expired) begin
          if (at_last) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE, ST_ERROR: state_d = state_q;
      default:           state_d = ST_FETCH;
    endcase

    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERROR);
    busy_d = !(done_d || err_d);

    if (i_restart) begin
      state_d  = ST_FETCH;
      addr_d   = '0;
      retry_d  = '0;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      busy_d   = 1'b1;
      tmr_load = 1'b0;
    end
  end

  assign o_rom_addr   = addr_q;
  assign o_sccb_valid = valid_q;
  assign o_sccb_reg   = req_q.regaddr;
  assign o_sccb_dat   = req_q.value;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: doc/cam_cfg_seq.md
CAM_CFG_SEQ -- requirements
Module: cam_cfg_seq

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25_000_000, the i_clk frequency in Hz.
REQ-002 SHALL have parameter DELAY_US, default 1000, the wait length in microseconds for a delay entry.
REQ-003 SHALL have parameter MAX_RETRY, default 3, the number of re-issues allowed after a NACK.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: i_clk in 1, rising-edge clock.
REQ-005 i_rstn in 1: asynchronous active-low reset.
REQ-006 i_restart in 1: single-cycle pulse that re-runs the sequence from address 0.
REQ-007 o_rom_addr out 8: config ROM address.
REQ-008 i_rom_data in 16: ROM word; [15:8] is the register, [7:0] is the value; 1-cycle registered latency.
REQ-009 o_sccb_valid out 1: write request to the SCCB master.
REQ-010 o_sccb_reg out 8: register address of the request.
REQ-011 o_sccb_dat out 8: write data of the request.
REQ-012 i_sccb_ready in 1: master accepts the request when valid and ready are both high.
REQ-013 i_sccb_done in 1: single-cycle pulse when the bus transaction completes.
REQ-014 i_sccb_nack in 1: sampled together with i_sccb_done; high means the slave did not acknowledge.
REQ-015 o_busy out 1: sequence in progress.
REQ-016 o_done out 1: sequence completed successfully; held high.
REQ-017 o_err out 1: sequence aborted on retry exhaustion; held high.

Function
REQ-018 States SHALL be FETCH, WAIT_ROM, DECODE, ISSUE, WAIT_BUS, DELAY, DONE, ERROR.
REQ-019 After reset, the block SHALL enter FETCH with address 0, so the sequence starts without a request.
REQ-020 FETCH → WAIT_ROM → DECODE: i_rom_data SHALL be sampled exactly 2 edges after o_rom_addr changes.
REQ-021 DECODE, word 16'hFFFF (end marker) → DONE.
REQ-022 DECODE, word 16'hFFF0 → DELAY; counter = CLK_HZ/1_000_000*DELAY_US − 1 (integer, computed at elaboration), counts to 0, then address+1 → FETCH.
REQ-023 DECODE, any other word → latch the register and value into o_sccb_reg/o_sccb_dat, then → ISSUE.
REQ-024 ISSUE SHALL hold o_sccb_valid high and reg/dat stable until i_sccb_ready is seen; the handshake cycle → WAIT_BUS, and valid drops on the next edge.
REQ-025 WAIT_BUS, i_sccb_done with nack=0 → clear the retry count, address+1, → FETCH.
REQ-026 WAIT_BUS, i_sccb_done with nack=1 and retry<MAX_RETRY → retry+1, → ISSUE with the same reg/dat; address unchanged.
REQ-027 WAIT_BUS, i_sccb_done with nack=1 and retry==MAX_RETRY → ERROR.
REQ-028 An address increment from 255 SHALL go to DONE, not wrap to 0.
REQ-029 i_restart in any state SHALL force address 0, retry 0, valid 0, done 0, err 0, → FETCH; it takes priority over every other transition in that cycle.
REQ-030 An i_sccb_done pulse outside WAIT_BUS SHALL be ignored.
REQ-031 o_busy SHALL be 1 in every state except DONE and ERROR.
REQ-032 No new request SHALL be issued before the previous one reports done.

Reset
REQ-033 Asynchronous assertion SHALL force: o_rom_addr=0, o_sccb_valid=0, reg/dat=0, o_busy=1, o_done=0, o_err=0, retry=0, delay counter=0, state=FETCH.
REQ-034 Reset in the middle of a delay or bus transaction SHALL abandon it; an i_sccb_done arriving later SHALL be ignored per REQ-030.

Structure
REQ-035 A shared package cam_cfg_pkg SHALL hold the state encoding and the marker constants CFG_END=16'hFFFF and CFG_DELAY=16'hFFF0; the ROM uses the same constants.
REQ-036 One sub-module SHALL exist: cfg_delay_timer (load, count-down, single-cycle expired pulse).
REQ-037 Everything else SHALL be a single FSM with registered outputs.

Verification
REQ-038 ROM {1280, FFF0, 1208, FFFF}, CLK_HZ=1e6, DELAY_US=10: expect two SCCB writes (0x12/0x80, then 0x12/0x08), with the second valid ≥10 cycles after the first done; then o_done=1, o_busy=0.
REQ-039 Hold ready low for 5 cycles during ISSUE: o_sccb_valid stays high with reg/dat stable; exactly one handshake occurs.
REQ-040 NACK on the first 2 attempts of word 0x3A04, then ACK: expect 3 identical issues, o_err=0, address advances to the next entry.
REQ-041 NACK on 4 consecutive attempts with MAX_RETRY=3: expect o_err=1, o_busy=0, no further valid.
REQ-042 ROM with no FFFF entry: after 256 entries, o_done=1 and o_rom_addr is not reissued at 0.
REQ-043 Assert i_rstn low in WAIT_BUS and i_restart in DELAY: both restart at address 0; a stray done is ignored.
